// File: rtl/soe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soe_pkg
// Description : Shared types, legal parameter ranges and the saturating
//               increment helper for the sum-of-errors monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package soe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } soe_state_t;

  localparam int c_num_ch_min = 1;
  localparam int c_num_ch_max = 64;
  localparam int c_delay_min  = 0;
  localparam int c_delay_max  = 15;
  localparam int c_cnt_w_max  = 64;
  localparam int c_fill_w     = 4;

  // Increment val, holding at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
    logic [63:0] lim;
    lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= lim) ? val : val + 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/soe_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : soe_delay_line
// Description : WIDTH-wide, DEPTH-deep shift register; wire when DEPTH=0.
// Revision    : 1.0 - initial release
// ============================================================================
module soe_delay_line
  import soe_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q              = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
          r_stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/soe_monitor.sv
`default_nettype none
// ============================================================================
// Module      : soe_monitor
// Description : Delayed golden-compare of NUM_CH outputs with saturating
//               per-channel/total error counts and first-error capture.
// Revision    : 1.0 - initial release
// ============================================================================
module soe_monitor
  import soe_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DELAY  = 0,
  parameter int CNT_W  = 32,
  parameter int CYC_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CYC_W-1:0]        max_cycles,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [NUM_CH-1:0]       dut_out,
  input  logic [NUM_CH-1:0]       golden,
  output logic                    busy,
  output logic                    done,
  output logic [CYC_W-1:0]        sample_idx,
  output logic [NUM_CH*CNT_W-1:0] soe_cnt,
  output logic [CNT_W-1:0]        soe_total,
  output logic                    first_err_valid,
  output logic [CYC_W-1:0]        first_err_idx
);

  generate
    if (NUM_CH < c_num_ch_min || NUM_CH > c_num_ch_max) begin : g_bad_num_ch
      $error("soe_monitor: NUM_CH outside legal range");
    end
    if (DELAY < c_delay_min || DELAY > c_delay_max) begin : g_bad_delay
      $error("soe_monitor: DELAY outside legal range");
    end
    if (CNT_W < 1 || CNT_W > c_cnt_w_max) begin : g_bad_cnt_w
      $error("soe_monitor: CNT_W outside legal range");
    end
  endgenerate

  soe_state_t          r_state;
  soe_state_t          w_next;
  logic                w_load;
  logic                w_cmp;
  logic                w_last;
  logic [c_fill_w-1:0] r_fill;
  logic [CYC_W-1:0]    r_max;
  logic [NUM_CH-1:0]   r_mask;
  logic [NUM_CH-1:0]   w_delayed;
  logic [NUM_CH-1:0]   w_mismatch;
  logic [CYC_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_total;
  logic                r_fev;
  logic [CYC_W-1:0]    r_fei;

  soe_delay_line #(
    .WIDTH (NUM_CH),
    .DEPTH (DELAY)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d   (dut_out),
    .q   (w_delayed)
  );

  assign w_mismatch = (w_delayed ^ golden) & r_mask;
  assign w_last     = (r_idx == r_max - CYC_W'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_cmp  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        done = (r_state == DONE);
        // start takes priority over a coincident abort here
        if (start) begin
          w_load = 1'b1;
          if (DELAY > 0)              w_next = FILL;
          else if (max_cycles == '0) w_next = DONE;
          else                        w_next = RUN;
        end
      end
      FILL: begin
        busy = 1'b1;
        if (abort)                                    w_next = DONE;
        else if (r_fill == c_fill_w'(DELAY - 1))      w_next = (r_max == '0) ? DONE : RUN;
      end
      RUN: begin
        busy  = 1'b1;
        w_cmp = 1'b1;
        if (abort || w_last) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_load)       r_fill <= '0;
    else if (r_state == FILL) r_fill <= r_fill + c_fill_w'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_max   <= '0;
      r_mask  <= '0;
      r_idx   <= '0;
      r_total <= '0;
      r_fev   <= 1'b0;
      r_fei   <= '0;
    end else if (w_load) begin
      r_max   <= max_cycles;
      r_mask  <= ch_mask;
      r_idx   <= '0;
      r_total <= '0;
      r_fev   <= 1'b0;
      r_fei   <= '0;
    end else if (w_cmp) begin
      // index freezes on the final compare so it never passes max_cycles-1
      if (!(abort || w_last)) r_idx <= r_idx + CYC_W'(1);
      if (|w_mismatch) begin
        r_total <= CNT_W'(sat_inc(64'(r_total), CNT_W));
        if (!r_fev) begin
          r_fev <= 1'b1;
          r_fei <= r_idx;
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst || w_load)              r_cnt <= '0;
        else if (w_cmp && w_mismatch[i]) r_cnt <= CNT_W'(sat_inc(64'(r_cnt), CNT_W));
      end

      assign soe_cnt[i*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate

  assign sample_idx      = r_idx;
  assign soe_total       = r_total;
  assign first_err_valid = r_fev;
  assign first_err_idx   = r_fei;

endmodule
`default_nettype wire

// File: doc/soe_monitor.md
# soe_monitor

Synthesizable, parametrised successor to the single-output golden-compare loop used in fault-injection campaigns. Each clock cycle it compares NUM_CH DUT output bits, delayed by a configurable number of cycles, against externally supplied golden bits. It accumulates saturating per-channel and total sum-of-errors (SoE) counts and captures the cycle of the first mismatch. A run-control FSM bounds every run to a programmed number of compared samples. The block sits beside the emulated DUT on the FPGA and replaces file-based comparison.

## Interface
- NUM_CH, 2: number of compared output channels (1..64)
- DELAY, 0: pipeline stages applied to dut_out before compare (0..15)
- CNT_W, 32: width of each SoE counter
- CYC_W, 32: width of cycle/sample counters

- clk  in  1  system clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- abort  in  1  ends a run early (RUN -> DONE)
- max_cycles  in  CYC_W  number of samples to compare; latched on start
- ch_mask  in  NUM_CH  1 = channel compared; latched on start
- dut_out  in  NUM_CH  DUT outputs
- golden  in  NUM_CH  golden values aligned to the compare cycle
- busy  out  1  high in RUN
- done  out  1  high in DONE
- sample_idx  out  CYC_W  index of the sample compared this cycle
- soe_cnt  out  NUM_CH*CNT_W  per-channel error counts; channel i at [i*CNT_W +: CNT_W]
- soe_total  out  CNT_W  samples with at least one masked mismatch
- first_err_valid  out  1  a mismatch has occurred in this run
- first_err_idx  out  CYC_W  sample_idx of the first mismatch

## Operation
- States: IDLE, FILL, RUN, DONE.
- Reset: state IDLE. All outputs are 0. The delay pipeline is 0.
- IDLE/DONE + start: latch max_cycles and ch_mask. Clear all counters, first_err_*, and sample_idx. Go to FILL if DELAY>0, otherwise RUN. DONE holds results until start.
- FILL: lasts exactly DELAY cycles. No compares. busy=1. Then go to RUN.
- RUN: compare d = dut_out delayed DELAY cycles against golden. mismatch = (d ^ golden) & ch_mask.
  - Each set bit increments soe_cnt[i].
  - If mismatch is nonzero, soe_total increments.
  - If mismatch is nonzero and first_err_valid=0, set first_err_valid and set first_err_idx = sample_idx.
  - sample_idx increments after each compare.
- Leave RUN for DONE after the compare with sample_idx == max_cycles-1.
- max_cycles == 0: go straight to DONE without entering RUN. This holds after FILL too.
- abort in FILL or RUN: go to DONE next cycle. The compare in the abort cycle still counts.
- start in FILL or RUN: ignored. start and abort together in IDLE/DONE: start wins.
- Counters saturate at all-ones and never wrap. sample_idx runs at most to max_cycles-1.
- rst mid-run returns to reset state on the next edge and discards results.

## Timing
- Compare-to-counter latency is 1 cycle: the count is visible the cycle after the compare.
- Delay path: the dut_out sampled at edge k is compared at edge k+DELAY.
- DELAY=0 compares combinational dut_out against golden at the same edge.
- done rises the cycle after the last compare, and the final counts are valid in that same cycle.
- A run occupies 1 + DELAY + max_cycles cycles from the start edge to the done rising edge.
- busy and done are never high together.

## Structure
- Package soe_pkg holds:
  - the state enum (IDLE, FILL, RUN, DONE)
  - a localparam function for the saturating increment
  - the DELAY and NUM_CH legal-range constants, checked by an elaboration assertion
- Sub-module soe_delay_line: a NUM_CH-wide, DELAY-deep shift register. It becomes a pass-through when DELAY=0, and it is reset by rst.
- Per-channel counters are generated in a for-generate loop in the top module.

## Test plan
- NUM_CH=2, DELAY=0, max_cycles=10, golden equal to dut_out except on samples 3 and 7 of ch1 -> soe_cnt[1]=2, soe_cnt[0]=0, soe_total=2, first_err_idx=3, done 11 cycles after start.
- DELAY=3, dut_out equal to golden shifted 3 cycles, max_cycles=100 -> all counts 0 and first_err_valid=0; with DELAY=2 on the same stimulus, counts are nonzero.
- ch_mask=2'b01 with mismatches only on ch1 -> soe_total=0 and soe_cnt[1]=0.
- CNT_W=4, a persistent mismatch for 40 samples -> soe_cnt saturates at 15.
- abort at sample 5 of 1000 -> done the next cycle, sample_idx stops at 5, counts include sample 5.
- rst asserted in RUN -> IDLE with all outputs 0 on the next cycle; max_cycles=0 with start -> done after 1+DELAY cycles with zero counts.
